keypad_rows_pio: RTL and testbench

Avalon-MM slave input port that reads the keypad row lines. The column output port strobes the columns, and this block samples the returned rows. It synchronizes and debounces each row and latches key-press (falling) edges. It raises an interrupt to the Nios II so the keypad scan driver does not busy-poll.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_debounce.sv | 63 ++++++
 rtl/keypad_rows_pio.sv | 97 +++++++++
 tb/tb_keypad_rows_pio.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared register map and defaults for the keypad PIO blocks
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // Column strobe port (output PIO) data register.
    localparam logic [1:0] ADDR_COL_DATA = 2'd0;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// keypad_debounce : 2-flop synchronizer plus counter debounce for one row line
// Revision        : 1.0
// ============================================================================
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_raw,
    output logic stable,
    output logic fall_pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        s1_d     = in_raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        fall_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            // Count would reach DEBOUNCE_CYCLES on this edge: accept the new level.
            stable_d = s2_q;
            cnt_d    = '0;
            fall_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign stable     = stable_q;
    assign fall_pulse = fall_d;

endmodule : keypad_debounce
`default_nettype wire

// File: rtl/keypad_rows_pio.sv
`default_nettype none
// ============================================================================
// keypad_rows_pio : Avalon-MM keypad row input port with debounce and press IRQ
// Revision        : 1.0
// ============================================================================
module keypad_rows_pio
    import keypad_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] fall_vec;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_row
            keypad_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_raw    (in_port[i]),
                .stable    (stable_vec[i]),
                .fall_pulse(fall_vec[i])
            );
        end
    endgenerate

    generate
        if (WIDTH < 32) begin : g_wdata_pad
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic [WIDTH-1:0] clr_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        wr_en      = chipselect & ~write_n;
        irq_mask_d = irq_mask_q;
        clr_vec    = '0;
        if (wr_en && (address == ADDR_IRQ_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE_CAP)) begin
            clr_vec = writedata[WIDTH-1:0];
        end
        // A press accepted on the clearing edge survives the clear.
        edge_cap_d = (edge_cap_q & ~clr_vec) | fall_vec;
        irq_d      = |(edge_cap_q & irq_mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = stable_vec;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:       readdata_d = '0;
        endcase
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule : keypad_rows_pio
`default_nettype wire

// File: tb/tb_keypad_rows_pio.sv
`default_nettype none
// ============================================================================
// tb_keypad_rows_pio : directed, table-driven bench for keypad_rows_pio
// Revision           : 1.0
// ============================================================================
module tb_keypad_rows_pio;

    localparam int W = 4;
    localparam int D = 4;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'd0;
    logic [W-1:0]  in_port = '1;
    logic [31:0]   readdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    keypad_rows_pio #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        bus_idle();
        check(name, readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        address    = v.addr;
        writedata  = v.wdata;
        chipselect = 1'b1;
        write_n    = ~v.wr;
        tick();
        bus_idle();
        if (v.chk_rd) check({name, "_rd"}, readdata, v.exp_rd);
        check({name, "_irq"}, {31'd0, irq}, {31'd0, v.exp_irq});
    endtask

    vec_t tbl_rst [4];
    vec_t tbl_irq [5];

    initial begin
        tbl_rst[0] = '{wr:1'b0, addr:2'd0, wdata:32'd0, chk_rd:1'b1, exp_rd:32'h0000000F, exp_irq:1'b0};
        tbl_rst[1] = '{wr:1'b0, addr:2'd1, wdata:32'd0, chk_rd:1'b1, exp_rd:32'h0,        exp_irq:1'b0};
        tbl_rst[2] = '{wr:1'b0, addr:2'd2, wdata:32'd0, chk_rd:1'b1, exp_rd:32'h0,        exp_irq:1'b0};
        tbl_rst[3] = '{wr:1'b0, addr:2'd3, wdata:32'd0, chk_rd:1'b1, exp_rd:32'h0,        exp_irq:1'b0};

        tbl_irq[0] = '{wr:1'b1, addr:2'd2, wdata:32'h1, chk_rd:1'b0, exp_rd:32'h0, exp_irq:1'b0};
        tbl_irq[1] = '{wr:1'b0, addr:2'd2, wdata:32'h0, chk_rd:1'b1, exp_rd:32'h1, exp_irq:1'b1};
        tbl_irq[2] = '{wr:1'b1, addr:2'd3, wdata:32'h1, chk_rd:1'b0, exp_rd:32'h0, exp_irq:1'b1};
        tbl_irq[3] = '{wr:1'b0, addr:2'd3, wdata:32'h0, chk_rd:1'b1, exp_rd:32'h0, exp_irq:1'b0};
        tbl_irq[4] = '{wr:1'b0, addr:2'd0, wdata:32'h0, chk_rd:1'b1, exp_rd:32'hE, exp_irq:1'b0};

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) run_vec(tbl_rst[i], $sformatf("rst%0d", i));

        // Row 0 press: stable falls on edge D+2, readdata one edge later
        address    = 2'd0;
        chipselect = 1'b1;
        write_n    = 1'b1;
        in_port    = 4'hE;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("press_data_e%0d", e), readdata, (e >= D + 3) ? 32'hE : 32'hF);
            check($sformatf("press_irq_e%0d", e), {31'd0, irq}, 32'd0);
        end
        bus_idle();
        rd(2'd3, 32'h1, "press_cap");

        // Mask enable raises irq, W1C drops it
        for (int i = 0; i < 5; i++) run_vec(tbl_irq[i], $sformatf("irq%0d", i));

        // Release is not captured
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd0, 32'hF, "release_data");
        rd(2'd3, 32'h0, "release_cap");

        // Glitch of D-1 cycles is filtered
        in_port = 4'hB;
        repeat (D - 1) tick();
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd0, 32'hF, "glitch3_data");
        rd(2'd3, 32'h0, "glitch3_cap");

        // Pulse of exactly D cycles is accepted
        in_port = 4'hB;
        repeat (D) tick();
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd3, 32'h4, "pulse4_cap");
        check("pulse4_irq_unmasked", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'hF, "pulse4_data");
        wr(2'd3, 32'h4);

        // Pre-load capture bit 0
        in_port = 4'hE;
        repeat (8) tick();
        in_port = 4'hF;
        repeat (8) tick();
        check("pre_irq", {31'd0, irq}, 32'd1);

        // Row 1 accepted on the same edge as a W1C of bits 1:0
        in_port = 4'hD;
        repeat (D + 1) tick();
        wr(2'd3, 32'h3);
        rd(2'd3, 32'h2, "set_wins_cap");
        check("set_wins_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'hD, "set_wins_data");
        in_port = 4'hF;
        repeat (10) tick();
        rd(2'd3, 32'h2, "release_ignored_cap");
        rd(2'd0, 32'hF, "release_ignored_data");

        // Async reset mid-debounce with row 3 held low
        wr(2'd2, 32'hF);
        tick();
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        in_port = 4'h7;
        repeat (D + 1) tick();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", readdata, 32'h0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        address    = 2'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        address = 2'd3;
        write_n = 1'b1;
        for (int e = 2; e <= D + 3; e++) begin
            tick();
            check($sformatf("post_rst_cap_e%0d", e), readdata, (e == D + 3) ? 32'h8 : 32'h0);
        end
        bus_idle();
        rd(2'd2, 32'h0, "post_rst_mask");
        check("post_rst_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'h7, "post_rst_data");
        repeat (10) tick();
        rd(2'd3, 32'h8, "post_rst_single_cap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_keypad_rows_pio
`default_nettype wire
